// File: rtl/dmem_port_ctrl_if.sv
// Pipeline-side bus of the data-memory port: M-stage request in, W-stage load data,
// stall and misalign back out.
interface dmem_port_ctrl_if;
    logic        MemReqM;
    logic        MemWriteM;
    logic [1:0]  MemSizeM;
    logic        MemSignedM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataW;
    logic        StallM;
    logic        MisalignM;

    modport master (
        output MemReqM, MemWriteM, MemSizeM, MemSignedM, AddrM, WriteDataM,
        input  ReadDataW, StallM, MisalignM
    );

    modport slave (
        input  MemReqM, MemWriteM, MemSizeM, MemSignedM, AddrM, WriteDataM,
        output ReadDataW, StallM, MisalignM
    );
endinterface

// File: rtl/dmem_port_ctrl.sv
// Data-RAM sequencer: pipeline loads/stores (sub-word stores by read-modify-write) plus a
// word-wide loader port. Define DMEM_STARVE_GUARD_EN to force loader grants after STARVE_MAX waits.
module dmemByteLane (
    input  logic       sel,
    input  logic [7:0] oldByte,
    input  logic [7:0] newByte,
    output logic [7:0] mergedByte
);
    assign mergedByte = sel ? newByte : oldByte;
endmodule

module dmem_port_ctrl #(
    parameter int AW         = 13,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_ctrl_if.slave      pipe,
    input  logic                 ld_req,
    input  logic                 ld_we,
    input  logic [AW-1:0]        ld_addr,
    input  logic [31:0]          ld_wdata,
    output logic                 ld_gnt,
    output logic                 ld_rvalid,
    output logic [31:0]          ld_rdata,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);
    localparam int NUM_LANES = 4;

`ifdef DMEM_STARVE_GUARD_EN
    typedef enum logic [1:0] {IDLE, RMW_WR, FORCE} state_t;
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starveCnt;
`else
    typedef enum logic [1:0] {IDLE, RMW_WR} state_t;
`endif

    typedef struct packed {
        logic [AW-1:0]          addr;
        logic [NUM_LANES-1:0]   sel;
        logic [31:0]            data;
    } rmwReq_t;

    state_t      state;
    rmwReq_t     rmw;
    logic        pipeLdPend;
    logic [1:0]  ldSize;
    logic        ldSgn;
    logic [1:0]  ldOff;
    logic [31:0] rdLast;
    logic [31:0] ldRdataQ;

    logic        isWord, isHalf, misalign, pipeGo, rmwStart;
    logic [1:0]  alignOff;
    logic [AW-1:0] pipeAddr;
    logic [31:0] rdShift, loadExt;
    logic [NUM_LANES-1:0][7:0] mergeBytes;

    assign isWord   = pipe.MemSizeM[1];
    assign isHalf   = (pipe.MemSizeM == 2'b01);
    assign alignOff = isWord ? 2'b00 : (isHalf ? {pipe.AddrM[1], 1'b0} : pipe.AddrM[1:0]);
    assign misalign = (isHalf & pipe.AddrM[0]) | (isWord & (|pipe.AddrM[1:0]));
    assign pipeAddr = pipe.AddrM[AW+1:2];

    // Lane merge for the write half of a read-modify-write
    for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
        dmemByteLane uLane (
            .sel        (rmw.sel[i]),
            .oldByte    (ram_rdata[8*i +: 8]),
            .newByte    (rmw.data[8*i +: 8]),
            .mergedByte (mergeBytes[i])
        );
    end

    assign rdShift = ram_rdata >> {ldOff, 3'b000};
    always_comb begin
        loadExt = ram_rdata;
        case (ldSize)
            2'b00:   loadExt = {{24{ldSgn & rdShift[7]}},  rdShift[7:0]};
            2'b01:   loadExt = {{16{ldSgn & rdShift[15]}}, rdShift[15:0]};
            default: loadExt = ram_rdata;
        endcase
    end

    assign pipe.ReadDataW = pipeLdPend ? loadExt : rdLast;
    assign ld_rdata       = ld_rvalid ? ram_rdata : ldRdataQ;

    // RAM-facing outputs are combinational so the RAM sees the request in its own cycle;
    // everything is forced quiet while reset is asserted.
    always_comb begin
        ram_we         = 1'b0;
        ram_addr       = pipeAddr;
        ram_wdata      = pipe.WriteDataM;
        ld_gnt         = 1'b0;
        pipe.StallM    = 1'b0;
        pipe.MisalignM = 1'b0;
        pipeGo         = 1'b0;
        rmwStart       = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (pipe.MemReqM) begin
                        pipeGo         = 1'b1;
                        pipe.MisalignM = misalign;
                        if (pipe.MemWriteM) begin
                            if (isWord) ram_we = 1'b1;
                            else begin
                                pipe.StallM = 1'b1;
                                rmwStart    = 1'b1;
                            end
                        end
                    end else if (ld_req) begin
                        ld_gnt    = 1'b1;
                        ram_addr  = ld_addr;
                        ram_we    = ld_we;
                        ram_wdata = ld_wdata;
                    end
                end
                RMW_WR: begin
                    ram_addr  = rmw.addr;
                    ram_we    = 1'b1;
                    ram_wdata = mergeBytes;
                end
`ifdef DMEM_STARVE_GUARD_EN
                FORCE: begin
                    pipe.StallM = 1'b1;
                    ld_gnt      = 1'b1;
                    ram_addr    = ld_addr;
                    ram_we      = ld_we;
                    ram_wdata   = ld_wdata;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rmw        <= '0;
            pipeLdPend <= 1'b0;
            ldSize     <= 2'b10;
            ldSgn      <= 1'b0;
            ldOff      <= 2'b00;
            rdLast     <= '0;
            ld_rvalid  <= 1'b0;
            ldRdataQ   <= '0;
`ifdef DMEM_STARVE_GUARD_EN
            starveCnt  <= '0;
`endif
        end else begin
            ld_rvalid  <= ld_gnt & ~ld_we;
            if (ld_rvalid) ldRdataQ <= ram_rdata;
            pipeLdPend <= pipeGo & ~pipe.MemWriteM;
            if (pipeGo & ~pipe.MemWriteM) begin
                ldSize <= isWord ? 2'b10 : pipe.MemSizeM;
                ldSgn  <= pipe.MemSignedM;
                ldOff  <= alignOff;
            end
            if (pipeLdPend) rdLast <= loadExt;

            case (state)
                IDLE: begin
`ifdef DMEM_STARVE_GUARD_EN
                    if (ld_gnt) starveCnt <= '0;
                    else if (ld_req && starveCnt < CW'(STARVE_MAX)) starveCnt <= starveCnt + 1'b1;
`endif
                    if (rmwStart) begin
                        state    <= RMW_WR;
                        rmw.addr <= pipeAddr;
                        rmw.sel  <= isHalf ? (4'b0011 << alignOff) : (4'b0001 << alignOff);
                        rmw.data <= isHalf ? {2{pipe.WriteDataM[15:0]}} : {4{pipe.WriteDataM[7:0]}};
                    end
`ifdef DMEM_STARVE_GUARD_EN
                    else if (ld_req && !ld_gnt && starveCnt >= CW'(STARVE_MAX - 1))
                        state <= FORCE;
`endif
                end
`ifdef DMEM_STARVE_GUARD_EN
                // The counter can only reach the limit here if it did so on the RMW issue cycle
                RMW_WR: state <= (ld_req && starveCnt >= CW'(STARVE_MAX)) ? FORCE : IDLE;
                FORCE: begin
                    state     <= IDLE;
                    starveCnt <= '0;
                end
`else
                RMW_WR: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
